accum_sched: RTL and testbench



---
 rtl/accum_sched.sv | 108 ++++++++++
 tb/tb_accum_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/accum_sched.sv
// accum_sched: round-robin scheduler sharing one accumulator among NREQ requesters.
// Optional idle watchdog enabled by defining ACCUM_SCHED_TIMEOUT_EN.
module accum #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + data;
endmodule

module accum_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int CW      = 8,
  parameter int TMO_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DW-1:0]            res_data,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [CW-1:0]            res_beats,
  output logic                     res_err
);
  localparam int IW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] ptr, g, sel;
  logic [CW-1:0] cnt;
  logic [DW-1:0] acc_q;
  logic grant, fire, tmo;
  function automatic logic [IW-1:0] wrap(input logic [IW:0] k);
    return (k >= (IW+1)'(NREQ)) ? IW'(k - (IW+1)'(NREQ)) : IW'(k);
  endfunction
  // lowest offset from ptr wins, so scan offsets from high to low
  always_comb begin
    sel = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[wrap({1'b0, ptr} + (IW+1)'(i))]) sel = wrap({1'b0, ptr} + (IW+1)'(i));
  end
  assign grant = state == IDLE && |req_valid;
  assign fire  = state == ACC && req_valid[g];
`ifdef ACCUM_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] wd;
  logic err;
  assign tmo = state == ACC && !req_valid[g] && wd == TW'(TMO_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      wd <= (state == ACC && !req_valid[g]) ? wd + 1'b1 : '0;
      if (grant) err <= 1'b0;
      else if (tmo) err <= 1'b1;
    end
  assign res_err = res_valid && err;
`else
  // TMO_CYC only matters with the watchdog built; this keeps it referenced
  assign tmo     = TMO_CYC < 0;
  assign res_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      g     <= '0;
      cnt   <= '0;
    end else begin
      if (grant) begin
        g     <= sel;
        cnt   <= '0;
        state <= ACC;
      end
      if (fire) cnt <= &cnt ? cnt : cnt + 1'b1;
      if ((fire && req_last[g]) || tmo) state <= DONE;
      if (state == DONE && res_ready) begin
        ptr   <= wrap({1'b0, g} + 1'b1);
        state <= IDLE;
      end
    end
  accum #(.DW(DW)) u_accum (
    .clk  (clk),
    .rst  (rst),
    .clr  (grant),
    .en   (fire),
    .data (req_data[g*DW +: DW]),
    .q    (acc_q)
  );
  assign req_ready = state == ACC ? NREQ'(1) << g : '0;
  assign res_valid = state == DONE;
  assign res_data  = res_valid ? acc_q : '0;
  assign res_id    = res_valid ? g : '0;
  assign res_beats = res_valid ? cnt : '0;
endmodule

// File: tb/tb_accum_sched.sv
// tb_accum_sched: randomized bursts scored against a queue-based round-robin model.
module tb_accum_sched;
  localparam int NREQ = 4, DW = 8, CW = 2, TMO = 16;
  typedef struct packed {
    logic [7:0] sum;
    logic [1:0] beats;
    logic       err;
  } res_t;
  logic clk, rst, res_valid, res_ready, res_err;
  logic [NREQ-1:0] req_valid, req_last, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [DW-1:0] res_data;
  logic [1:0] res_id;
  logic [CW-1:0] res_beats;
  accum_sched #(.NREQ(NREQ), .DW(DW), .CW(CW), .TMO_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_beats (res_beats),
    .res_err   (res_err)
  );
  always #5 clk = ~clk;
  int total, bad, mptr;
  logic [8:0] beat_q[NREQ][$];
  res_t exp_q[NREQ][$];
  bit mid[NREQ];
  int acc_cnt[NREQ];
  bit exp_done, bub_en, rr_force, rr_val, held;
  logic [7:0] h_data;
  logic [1:0] h_id, h_beats;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // queue each burst's beats for the driver and its expected result for the model
  task automatic load(int id, int n, logic [7:0] d0, logic [7:0] step, bit rnd, bit hang);
    logic [7:0] s, d;
    s = 0;
    for (int k = 0; k < n; k++) begin
      d = rnd ? 8'($urandom) : d0 + 8'(k) * step;
      s += d;
      beat_q[id].push_back({k == n - 1 && !hang, d});
    end
`ifdef ACCUM_SCHED_TIMEOUT_EN
    exp_q[id].push_back('{s, n > 3 ? 2'd3 : 2'(n), hang});
`else
    if (!hang) exp_q[id].push_back('{s, n > 3 ? 2'd3 : 2'(n), 1'b0});
`endif
  endtask
  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NREQ; i++) p += exp_q[i].size();
    return p;
  endfunction
  task automatic score();
    int e = -1;
    res_t x;
    for (int k = 0; k < NREQ; k++)
      if (e < 0 && exp_q[(mptr + k) % NREQ].size() > 0) e = (mptr + k) % NREQ;
    if (e < 0) check("unexpected_result", res_valid, 0);
    else begin
      x = exp_q[e].pop_front();
      check("res_id", res_id, e);
      check("res_data", res_data, x.sum);
      check("res_beats", res_beats, x.beats);
      check("res_err", res_err, x.err);
      mptr = (e + 1) % NREQ;
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (beat_q[i].size() > 0 && !(bub_en && mid[i] && $urandom_range(3) == 0)) begin
        req_valid[i] = 1'b1;
        req_last[i]  = beat_q[i][0][8];
        req_data[i*DW +: DW] = beat_q[i][0][7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'($urandom);
        req_data[i*DW +: DW] = 8'($urandom);
      end
    res_ready = rr_force ? rr_val : $urandom_range(3) != 0;
    #1;
    check("ready_onehot0", 32'($onehot0(req_ready)), 1);
    if (exp_done) check("valid_latency", res_valid, 1);
    exp_done = 0;
    if (res_valid) begin
      check("ready_in_done", req_ready, 0);
      if (held) begin
        check("hold_data", res_data, h_data);
        check("hold_id", res_id, h_id);
        check("hold_beats", res_beats, h_beats);
      end
      if (res_ready) begin
        score();
        held = 0;
      end else begin
        held = 1;
        h_data = res_data;
        h_id = res_id;
        h_beats = res_beats;
      end
    end else held = 0;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        acc_cnt[i]++;
        mid[i] = !beat_q[i][0][8];
        if (beat_q[i][0][8]) exp_done = 1;
        void'(beat_q[i].pop_front());
      end
  endtask
  task automatic drain(int budget);
    int c = 0;
    while ((pending() > 0 || res_valid) && c < budget) begin
      cycle();
      c++;
    end
    check("drain", pending(), 0);
  endtask
  task automatic do_reset();
    rst = 1;
    req_valid = '0;
    #1;
    check("rst_outs", {req_ready, res_valid, res_data, res_id, res_beats, res_err}, 0);
    for (int i = 0; i < NREQ; i++) begin
      beat_q[i].delete();
      exp_q[i].delete();
      mid[i] = 0;
      acc_cnt[i] = 0;
    end
    exp_done = 0;
    held = 0;
    mptr = 0;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    int c, seen;
    clk = 0;
    rst = 1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    res_ready = 0;
    total = 0;
    bad = 0;
    mptr = 0;
    repeat (2) @(negedge clk);
    check("reset_state", {req_ready, res_valid, res_data, res_id, res_beats, res_err}, 0);
    rst = 0;
    rr_force = 1;
    rr_val = 1;
    load(1, 3, 3, 1, 0, 0);
    drain(50);
    do_reset();
    for (int i = 0; i < NREQ; i++) load(i, 1, 8'(i + 1), 0, 0, 0);
    load(0, 1, 1, 0, 0, 0);
    drain(50);
    load(0, 5, 8'h80, 0, 0, 0);
    drain(50);
    rr_val = 0;
    load(1, 2, 9, 0, 0, 0);
    c = 0;
    while (!res_valid && c < 20) begin
      cycle();
      c++;
    end
    check("bp_reach_done", res_valid, 1);
    repeat (10) cycle();
    rr_val = 1;
    cycle();
    cycle();
    check("bp_complete", res_valid, 0);
    load(2, 5, 10, 10, 0, 0);
    c = 0;
    while (acc_cnt[2] < 2 && c < 30) begin
      cycle();
      c++;
    end
    cycle();
    do_reset();
    load(3, 2, 1, 1, 0, 0);
    load(0, 2, 6, 1, 0, 0);
    drain(50);
    bub_en = 1;
    rr_force = 0;
    repeat (25) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(1) == 1) load(i, $urandom_range(6, 1), 0, 0, 1, 0);
      drain(400);
    end
    bub_en = 0;
    rr_force = 1;
    rr_val = 1;
    load(3, 1, 7, 0, 0, 1);
`ifdef ACCUM_SCHED_TIMEOUT_EN
    drain(60);
`else
    seen = 0;
    repeat (100) begin
      cycle();
      seen += int'(res_valid);
    end
    check("no_timeout_result", seen, 0);
    do_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
